// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants, state type and forwarding helper for the
//            five-stage pipeline control unit.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  localparam logic [1:0] FWD_RF       = 2'd0;
  localparam logic [1:0] FWD_EXE_Z    = 2'd1;
  localparam logic [1:0] FWD_MEM_Z    = 2'd2;
  localparam logic [1:0] FWD_MEM_DOUT = 2'd3;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Youngest producer wins; a load in EXE has no data yet and is never a source.
  function automatic logic [1:0] fwd_pick(
    input logic [4:0] src,
    input logic       exe_we,
    input logic       exe_load,
    input logic [4:0] exe_waddr,
    input logic       mem_we,
    input logic       mem_load,
    input logic [4:0] mem_waddr
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (exe_we && !exe_load && (exe_waddr == src)) begin
        sel = FWD_EXE_Z;
      end else if (mem_we && (mem_waddr == src)) begin
        sel = mem_load ? FWD_MEM_DOUT : FWD_MEM_Z;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_timer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_timer
// Purpose  : Tracks EXE occupancy of MULT/DIV and produces busy/done.
// Revision : 1.0
// ============================================================================
module muldiv_timer
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_is_mul,
  input  logic exe_is_div,
  output logic busy,
  output logic done
);

  localparam int CW = ($clog2(DIV_CYCLES) < 1) ? 1 : $clog2(DIV_CYCLES);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  int            n_cycles;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    n_cycles = exe_is_div ? DIV_CYCLES : MUL_CYCLES;
    case (state_q)
      IDLE: begin
        if (exe_is_mul || exe_is_div) begin
          if (n_cycles == 1) begin
            done = 1'b1;
          end else begin
            busy    = 1'b1;
            cnt_d   = CW'(n_cycles - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          busy  = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts any operation in flight without a done pulse.
    if (rst) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall, flush, freeze and ID-operand forwarding control.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       branch_taken,
  input  logic       exe_rf_we,
  input  logic       exe_is_load,
  input  logic [4:0] exe_rf_waddr,
  input  logic       exe_is_mul,
  input  logic       exe_is_div,
  input  logic       mem_rf_we,
  input  logic       mem_is_load,
  input  logic [4:0] mem_rf_waddr,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       iereg_we,
  output logic       iereg_bubble,
  output logic       em_bubble,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel
);

  logic frozen;
  logic exe_hit;
  logic mem_hit;
  logic load_use;
  logic branch_stall;
  logic stall;

  muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_muldiv_timer (
    .clk       (clk),
    .rst       (rst),
    .exe_is_mul(exe_is_mul),
    .exe_is_div(exe_is_div),
    .busy      (frozen),
    .done      (muldiv_done)
  );

  assign muldiv_busy = frozen;

  always_comb begin
    exe_hit = (exe_rf_waddr != 5'd0) &&
              ((id_uses_rs && (exe_rf_waddr == id_rs)) ||
               (id_uses_rt && (exe_rf_waddr == id_rt)));
    mem_hit = (mem_rf_waddr != 5'd0) &&
              ((id_uses_rs && (mem_rf_waddr == id_rs)) ||
               (id_uses_rt && (mem_rf_waddr == id_rt)));
    load_use     = exe_is_load && exe_hit;
    branch_stall = id_is_branch &&
                   ((exe_rf_we && exe_hit) || (mem_is_load && mem_hit));
    stall        = !frozen && (load_use || branch_stall);
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    iereg_we     = 1'b1;
    ifid_flush   = 1'b0;
    iereg_bubble = 1'b0;
    em_bubble    = 1'b0;
    fwd_rs_sel   = fwd_pick(id_rs, exe_rf_we, exe_is_load, exe_rf_waddr,
                            mem_rf_we, mem_is_load, mem_rf_waddr);
    fwd_rt_sel   = fwd_pick(id_rt, exe_rf_we, exe_is_load, exe_rf_waddr,
                            mem_rf_we, mem_is_load, mem_rf_waddr);
    if (rst) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      iereg_we     = 1'b0;
      ifid_flush   = 1'b1;
      iereg_bubble = 1'b1;
      em_bubble    = 1'b1;
      fwd_rs_sel   = FWD_RF;
      fwd_rt_sel   = FWD_RF;
    end else if (frozen) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      iereg_we  = 1'b0;
      em_bubble = 1'b1;
    end else if (stall) begin
      // Branch stays in ID and re-resolves next cycle, so no flush yet.
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      iereg_bubble = 1'b1;
    end else begin
      ifid_flush = branch_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt, id_is_branch, branch_taken;
  logic       exe_rf_we, exe_is_load, exe_is_mul, exe_is_div;
  logic [4:0] exe_rf_waddr;
  logic       mem_rf_we, mem_is_load;
  logic [4:0] mem_rf_waddr;
  logic       pc_we, ifid_we, ifid_flush, iereg_we, iereg_bubble, em_bubble;
  logic       muldiv_busy, muldiv_done;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int n_total;
  int n_bad;

  pipe_hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_is_branch(id_is_branch),
    .branch_taken(branch_taken),
    .exe_rf_we   (exe_rf_we),
    .exe_is_load (exe_is_load),
    .exe_rf_waddr(exe_rf_waddr),
    .exe_is_mul  (exe_is_mul),
    .exe_is_div  (exe_is_div),
    .mem_rf_we   (mem_rf_we),
    .mem_is_load (mem_is_load),
    .mem_rf_waddr(mem_rf_waddr),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .iereg_we    (iereg_we),
    .iereg_bubble(iereg_bubble),
    .em_bubble   (em_bubble),
    .muldiv_busy (muldiv_busy),
    .muldiv_done (muldiv_done),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; branch_taken = 1'b0;
    exe_rf_we = 1'b0; exe_is_load = 1'b0; exe_rf_waddr = 5'd0;
    exe_is_mul = 1'b0; exe_is_div = 1'b0;
    mem_rf_we = 1'b0; mem_is_load = 1'b0; mem_rf_waddr = 5'd0;
  endtask

  task automatic check_idle_pipe(input string tag);
    check({tag, "_pc_we"},    pc_we, 1'b1);
    check({tag, "_ifid_we"},  ifid_we, 1'b1);
    check({tag, "_iereg_we"}, iereg_we, 1'b1);
    check({tag, "_ibub"},     iereg_bubble, 1'b0);
    check({tag, "_embub"},    em_bubble, 1'b0);
    check({tag, "_done"},     muldiv_done, 1'b0);
  endtask

  // Hold a mul/div in EXE for n cycles: n-1 frozen, then done.
  task automatic run_muldiv(input string tag, input logic is_div, input int n);
    exe_is_div = is_div;
    exe_is_mul = !is_div;
    branch_taken = 1'b1;
    for (int i = 0; i < n - 1; i++) begin
      settle();
      check({tag, "_busy"},  muldiv_busy, 1'b1);
      check({tag, "_pc_we"}, pc_we, 1'b0);
      check({tag, "_iewe"},  iereg_we, 1'b0);
      check({tag, "_embub"}, em_bubble, 1'b1);
      check({tag, "_flush"}, ifid_flush, 1'b0);
      check({tag, "_nodone"}, muldiv_done, 1'b0);
      tick();
    end
    settle();
    check({tag, "_done"},     muldiv_done, 1'b1);
    check({tag, "_idle"},     muldiv_busy, 1'b0);
    check({tag, "_adv_pc"},   pc_we, 1'b1);
    check({tag, "_adv_flush"}, ifid_flush, 1'b1);
    branch_taken = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_is_branch = 1'($urandom); branch_taken = 1'($urandom);
      exe_rf_we = 1'($urandom); exe_is_load = 1'($urandom);
      exe_rf_waddr = 5'($urandom);
      exe_is_mul = 1'($urandom); exe_is_div = 1'($urandom);
      mem_rf_we = 1'($urandom); mem_is_load = 1'($urandom);
      mem_rf_waddr = 5'($urandom);
      settle();
      check("rst_pc_we",  pc_we, 1'b0);
      check("rst_ifid_we", ifid_we, 1'b0);
      check("rst_iereg_we", iereg_we, 1'b0);
      check("rst_flush",  ifid_flush, 1'b1);
      check("rst_ibub",   iereg_bubble, 1'b1);
      check("rst_embub",  em_bubble, 1'b1);
      check("rst_busy",   muldiv_busy, 1'b0);
      check("rst_done",   muldiv_done, 1'b0);
      check("rst_fwd_rs", fwd_rs_sel, 2'd0);
      check("rst_fwd_rt", fwd_rt_sel, 2'd0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    settle();
    check_idle_pipe("post_rst");
    check("post_rst_flush", ifid_flush, 1'b0);

    // Load-use: lw $5 in EXE, add $6,$5,$7 in ID
    tick();
    id_rs = 5'd5; id_rt = 5'd7; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    exe_rf_we = 1'b1; exe_is_load = 1'b1; exe_rf_waddr = 5'd5;
    settle();
    check("lu_pc_we",   pc_we, 1'b0);
    check("lu_ifid_we", ifid_we, 1'b0);
    check("lu_iereg_we", iereg_we, 1'b1);
    check("lu_ibub",    iereg_bubble, 1'b1);
    check("lu_fwd_rs",  fwd_rs_sel, 2'd0);
    tick();
    exe_rf_we = 1'b0; exe_is_load = 1'b0; exe_rf_waddr = 5'd0;
    mem_rf_we = 1'b1; mem_is_load = 1'b1; mem_rf_waddr = 5'd5;
    settle();
    check("lu2_fwd_rs", fwd_rs_sel, 2'd3);
    check("lu2_fwd_rt", fwd_rt_sel, 2'd0);
    check_idle_pipe("lu2");

    // Branch stall: beq $3,$0 with EXE writing $3, taken
    tick();
    clear_inputs();
    id_rs = 5'd3; id_rt = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    id_is_branch = 1'b1; branch_taken = 1'b1;
    exe_rf_we = 1'b1; exe_rf_waddr = 5'd3;
    settle();
    check("br_pc_we", pc_we, 1'b0);
    check("br_flush", ifid_flush, 1'b0);
    check("br_ibub",  iereg_bubble, 1'b1);
    check("br_fwd_rs", fwd_rs_sel, 2'd1);
    tick();
    exe_rf_we = 1'b0; exe_rf_waddr = 5'd0;
    mem_rf_we = 1'b1; mem_rf_waddr = 5'd3;
    settle();
    check("br2_fwd_rs", fwd_rs_sel, 2'd2);
    check("br2_fwd_rt", fwd_rt_sel, 2'd0);
    check("br2_flush",  ifid_flush, 1'b1);
    check_idle_pipe("br2");
    // Load in MEM feeding a branch still stalls
    mem_is_load = 1'b1;
    settle();
    check("brld_pc_we", pc_we, 1'b0);
    check("brld_flush", ifid_flush, 1'b0);
    check("brld_fwd_rs", fwd_rs_sel, 2'd3);

    // Writes to $0 never stall or forward
    tick();
    clear_inputs();
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_is_branch = 1'b1;
    exe_rf_we = 1'b1; exe_is_load = 1'b1;
    mem_rf_we = 1'b1; mem_is_load = 1'b1;
    settle();
    check("r0_pc_we", pc_we, 1'b1);
    check("r0_ibub",  iereg_bubble, 1'b0);
    check("r0_fwd_rs", fwd_rs_sel, 2'd0);
    check("r0_fwd_rt", fwd_rt_sel, 2'd0);
    // EXE and MEM both writing $4: EXE wins
    tick();
    clear_inputs();
    id_rs = 5'd4; id_rt = 5'd7; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    exe_rf_we = 1'b1; exe_rf_waddr = 5'd4;
    mem_rf_we = 1'b1; mem_rf_waddr = 5'd4;
    settle();
    check("both_fwd_rs", fwd_rs_sel, 2'd1);
    check("both_fwd_rt", fwd_rt_sel, 2'd0);
    check_idle_pipe("both");

    // DIV then back-to-back MULT
    tick();
    clear_inputs();
    run_muldiv("div", 1'b1, 32);
    tick();
    run_muldiv("mul", 1'b0, 4);
    tick();
    clear_inputs();
    settle();
    check("after_md_busy", muldiv_busy, 1'b0);
    check_idle_pipe("after_md");

    // Both flags set: div length wins
    tick();
    exe_is_mul = 1'b1;
    exe_is_div = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("both_flags_busy", muldiv_busy, 1'b1);
    check("both_flags_done", muldiv_done, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();

    // Reset during BUSY cycle 10 of a DIV
    tick();
    exe_is_div = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    settle();
    check("mid_busy", muldiv_busy, 1'b1);
    rst = 1'b1;
    settle();
    check("mid_rst_done", muldiv_done, 1'b0);
    tick();
    rst = 1'b0;
    exe_is_div = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("abort_busy", muldiv_busy, 1'b0);
      check("abort_done", muldiv_done, 1'b0);
      tick();
    end
    run_muldiv("div2", 1'b1, 32);
    tick();
    clear_inputs();
    settle();
    check("end_busy", muldiv_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
